// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the pipeline control blocks:
// major opcode encodings, the canonical NOP word, the hazard controller
// state type and an EBREAK recogniser.
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // funct12 of 1 separates EBREAK from ECALL (funct12 of 0).
  localparam logic [11:0] F12_EBREAK = 12'h001;

  localparam logic [31:0] NOP_IW = 32'h0000_0013;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} hz_state_t;

  function automatic logic is_ebreak(input logic [31:0] iw);
    return (iw[6:0] == OP_SYSTEM) && (iw[31:20] == F12_EBREAK);
  endfunction

endpackage

// File: rtl/rv32i_src_decode.sv
// Source-register decode for the instruction in ID.
// Ports:
//   id_iw    in  32  instruction word in ID
//   rs1_used out 1   instruction reads rs1
//   rs2_used out 1   instruction reads rs2
//   rs1      out 5   rs1 field
//   rs2      out 5   rs2 field
module rv32i_src_decode
  import rv32i_pkg::*;
(
  input  logic [31:0] id_iw,
  output logic        rs1_used,
  output logic        rs2_used,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  logic [6:0] opc;
  logic       unused_iw_bits;

  assign opc = id_iw[6:0];
  assign rs1 = id_iw[19:15];
  assign rs2 = id_iw[24:20];

  // rd, funct3 and funct7 play no part in source usage.
  assign unused_iw_bits = ^{id_iw[31:25], id_iw[14:7]};

  always_comb begin
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opc)
      OP_LUI, OP_AUIPC, OP_JAL:  rs1_used = 1'b0;
      default:                   rs1_used = 1'b1;
    endcase
    case (opc)
      OP_R, OP_STORE, OP_BRANCH: rs2_used = 1'b1;
      default:                   rs2_used = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core.
// Detects load-use hazards between EX and ID, flushes on taken
// branches/jumps resolved in EX, and drains the pipe to a halt on EBREAK.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   id_iw, ex_iw       instruction words in ID and EX
//   ex_br_taken        EX resolved a taken branch/jump this cycle
//   pc_hold, ifid_hold freeze PC / IF-ID register
//   ifid_flush         load NOP into IF-ID
//   idex_bubble        load NOP into ID-EX
//   halted             core halted after EBREAK drain
//   stall_cnt          saturating count of load-use stall cycles
//   flush_cnt          saturating count of branch flush events
module rv32i_hazard_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_iw,
  input  logic [31:0]      ex_iw,
  input  logic             ex_br_taken,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  hz_state_t        state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;

  logic             rs1_used, rs2_used;
  logic [4:0]       rs1, rs2;
  logic [4:0]       ex_rd;
  logic             load_use;
  logic             unused_ex_bits;

  rv32i_src_decode u_src_decode (
    .id_iw    (id_iw),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .rs1      (rs1),
    .rs2      (rs2)
  );

  assign ex_rd          = ex_iw[11:7];
  assign unused_ex_bits = ^ex_iw[31:12];

  assign load_use = (ex_iw[6:0] == OP_LOAD) && (ex_rd != 5'd0) &&
                    ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    case (state_q)
      RUN: begin
        // A taken branch makes whatever sits in ID wrong-path, so it
        // outranks any hazard or EBREAK seen there.
        if (ex_br_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_inc   = 1'b1;
        end else if (load_use) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
        end else if (is_ebreak(id_iw)) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          state_d     = DRAIN;
          drain_d     = DW'(DRAIN_CYC - 1);
        end
      end
      DRAIN: begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
        if (drain_q == '0) state_d = HALT;
        else               drain_d = drain_q - 1'b1;
      end
      HALT: begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (reset) begin
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      drain_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign halted    = (state_q == HALT);
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
module tb_rv32i_hazard_ctrl;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] id_iw = NOP_IW;
  logic [31:0] ex_iw = NOP_IW;
  logic        ex_br_taken = 1'b0;

  logic        ph, fh, fl, bub, hlt;
  logic [15:0] stall_cnt, flush_cnt;
  logic        ph4, fh4, fl4, bub4, hlt4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  rv32i_hazard_ctrl #(.CNT_W(16), .DRAIN_CYC(3)) dut (
    .clk(clk), .reset(reset), .id_iw(id_iw), .ex_iw(ex_iw), .ex_br_taken(ex_br_taken),
    .pc_hold(ph), .ifid_hold(fh), .ifid_flush(fl), .idex_bubble(bub), .halted(hlt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  rv32i_hazard_ctrl #(.CNT_W(4), .DRAIN_CYC(3)) dut4 (
    .clk(clk), .reset(reset), .id_iw(id_iw), .ex_iw(ex_iw), .ex_br_taken(ex_br_taken),
    .pc_hold(ph4), .ifid_hold(fh4), .ifid_flush(fl4), .idex_bubble(bub4), .halted(hlt4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  always #5 clk = ~clk;

  // Hand-assembled instruction words
  localparam logic [31:0] LW_X5    = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] LW_X0    = 32'h0000_A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD_652  = 32'h0022_8333; // add  x6,x5,x2
  localparam logic [31:0] ADD_602  = 32'h0020_0333; // add  x6,x0,x2
  localparam logic [31:0] ADD_655  = 32'h0052_8333; // add  x6,x5,x5
  localparam logic [31:0] LUI_X5   = 32'h0000_12B7; // lui  x5,1
  localparam logic [31:0] LUI_R5   = 32'h0002_83B7; // lui  x7,0x28 (rs1 field = 5)
  localparam logic [31:0] ADDI_R5  = 32'h0050_0313; // addi x6,x0,5 (rs2 field = 5)
  localparam logic [31:0] SW_X5    = 32'h0050_A023; // sw   x5,0(x1)
  localparam logic [31:0] EBRK     = 32'h0010_0073; // ebreak

  // {pc_hold, ifid_hold, ifid_flush, idex_bubble}
  localparam logic [3:0] C_NONE  = 4'b0000;
  localparam logic [3:0] C_HOLD  = 4'b1101;
  localparam logic [3:0] C_FLUSH = 4'b0011;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [3:0]  ctl;
    logic        h;
    bit          hchk;
    int unsigned st;
    int unsigned fl;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int unsigned st_e = 0;
  int unsigned fl_e = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned sat15(input int unsigned v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every queued expectation stamped for this cycle.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      mon_e = sbq.pop_front();
      chk({mon_e.name, ".ctl"},        {28'd0, ph, fh, fl, bub},      {28'd0, mon_e.ctl});
      chk({mon_e.name, ".ctl4"},       {28'd0, ph4, fh4, fl4, bub4},  {28'd0, mon_e.ctl});
      if (mon_e.hchk) begin
        chk({mon_e.name, ".halted"},   {31'd0, hlt},  {31'd0, mon_e.h});
        chk({mon_e.name, ".halted4"},  {31'd0, hlt4}, {31'd0, mon_e.h});
      end
      chk({mon_e.name, ".stall_cnt"},  {16'd0, stall_cnt},  mon_e.st);
      chk({mon_e.name, ".flush_cnt"},  {16'd0, flush_cnt},  mon_e.fl);
      chk({mon_e.name, ".stall_cnt4"}, {28'd0, stall_cnt4}, sat15(mon_e.st));
      chk({mon_e.name, ".flush_cnt4"}, {28'd0, flush_cnt4}, sat15(mon_e.fl));
    end
  end

  // One cycle of stimulus; the expectation carries the counter values
  // visible during this cycle, the model is advanced after the edge.
  task automatic step(input string nm, input logic [31:0] id, input logic [31:0] ex,
                      input logic br, input logic rst, input logic [3:0] ctl,
                      input logic h, input bit hchk, input bit inc_st, input bit inc_fl);
    exp_t e;
    id_iw       = id;
    ex_iw       = ex;
    ex_br_taken = br;
    reset       = rst;
    e.cyc  = cyc;
    e.name = nm;
    e.ctl  = ctl;
    e.h    = h;
    e.hchk = hchk;
    e.st   = st_e;
    e.fl   = fl_e;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (rst) begin
      st_e = 0;
      fl_e = 0;
    end else begin
      st_e += inc_st;
      fl_e += inc_fl;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not end, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // Reset gates a would-be load-use
    step("reset",        ADD_652, LW_X5,  1'b0, 1'b1, C_NONE,  1'b0, 1, 0, 0);
    // Load-use: exactly one stall cycle
    step("lu_stall",     ADD_652, LW_X5,  1'b0, 1'b0, C_HOLD,  1'b0, 1, 1, 0);
    step("lu_after",     ADD_652, NOP_IW, 1'b0, 1'b0, C_NONE,  1'b0, 1, 0, 0);
    // Non-stalling cases
    step("rd_x0",        ADD_602, LW_X0,  1'b0, 1'b0, C_NONE,  1'b0, 1, 0, 0);
    step("lui_x5",       LUI_X5,  LW_X5,  1'b0, 1'b0, C_NONE,  1'b0, 1, 0, 0);
    step("lui_rs1fld",   LUI_R5,  LW_X5,  1'b0, 1'b0, C_NONE,  1'b0, 1, 0, 0);
    step("addi_rs2fld",  ADDI_R5, LW_X5,  1'b0, 1'b0, C_NONE,  1'b0, 1, 0, 0);
    // Store reads rs2
    step("sw_rs2",       SW_X5,   LW_X5,  1'b0, 1'b0, C_HOLD,  1'b0, 1, 1, 0);
    step("idle1",        NOP_IW,  NOP_IW, 1'b0, 1'b0, C_NONE,  1'b0, 1, 0, 0);
    // Branch flush outranks load-use and EBREAK
    step("br_lu",        ADD_655, LW_X5,  1'b1, 1'b0, C_FLUSH, 1'b0, 1, 0, 1);
    step("br_ebrk",      EBRK,    NOP_IW, 1'b1, 1'b0, C_FLUSH, 1'b0, 1, 0, 1);
    step("post_br",      NOP_IW,  NOP_IW, 1'b0, 1'b0, C_NONE,  1'b0, 1, 0, 0);
    // Saturation of the 4-bit instance
    for (int i = 0; i < 20; i++)
      step("sat_stall",  ADD_652, LW_X5,  1'b0, 1'b0, C_HOLD,  1'b0, 1, 1, 0);
    step("post_sat",     NOP_IW,  NOP_IW, 1'b0, 1'b0, C_NONE,  1'b0, 1, 0, 0);
    // Reset in DRAIN
    step("ebrk_a",       EBRK,    NOP_IW, 1'b0, 1'b0, C_HOLD,  1'b0, 1, 0, 0);
    step("drain_a",      NOP_IW,  NOP_IW, 1'b0, 1'b0, C_HOLD,  1'b0, 1, 0, 0);
    step("rst_drain",    NOP_IW,  NOP_IW, 1'b0, 1'b1, C_NONE,  1'b0, 1, 0, 0);
    for (int i = 0; i < 6; i++)
      step("after_rst_a", NOP_IW, NOP_IW, 1'b0, 1'b0, C_NONE,  1'b0, 1, 0, 0);
    // EBREAK drain to halt; branch in DRAIN ignored
    step("ebrk",         EBRK,    NOP_IW, 1'b0, 1'b0, C_HOLD,  1'b0, 1, 0, 0);
    step("drain1",       NOP_IW,  NOP_IW, 1'b0, 1'b0, C_HOLD,  1'b0, 1, 0, 0);
    step("drain2_br",    NOP_IW,  NOP_IW, 1'b1, 1'b0, C_HOLD,  1'b0, 1, 0, 0);
    step("drain3",       NOP_IW,  NOP_IW, 1'b0, 1'b0, C_HOLD,  1'b0, 1, 0, 0);
    for (int i = 0; i < 100; i++)
      step("halt",       ADD_652, LW_X5, ((i % 3) == 0), 1'b0, C_HOLD, 1'b1, 1, 0, 0);
    // Reset releases HALT on the next edge
    step("rst_halt",     NOP_IW,  NOP_IW, 1'b0, 1'b1, C_NONE,  1'b0, 0, 0, 0);
    step("after_rst_b",  NOP_IW,  NOP_IW, 1'b0, 1'b0, C_NONE,  1'b0, 1, 0, 0);
    step("run_stall",    ADD_652, LW_X5,  1'b0, 1'b0, C_HOLD,  1'b0, 1, 1, 0);
    step("final",        NOP_IW,  NOP_IW, 1'b0, 1'b0, C_NONE,  1'b0, 1, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
